pc_decode_unit: RTL and testbench
=================================

PC_DECODE_UNIT -- requirements
Module: pc_decode_unit

Interface
REQ-001 Parameter: PC_RESET, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter: CNT_W, 16, width of the retired-instruction counter.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: stall  input  1  hold PC; suppress register write.
REQ-006 Port: instr  input  32  instruction word at PC (combinational instruction memory).
REQ-007 Port: EQ  input  1  zero/equal flag from the ALU stage, same cycle.
REQ-008 Port: PC  output  32  current program counter (registered).
REQ-009 Port: AD1, AD2, AD3  output  5 each  rs1, rs2, rd fields of instr.
REQ-010 Port: WE3, ALUSrc, ALUCtrl  output  1 each  register write enable, immediate-operand select, 0=add/1=sub.
REQ-011 Port: ImmOp  output  32  sign-extended immediate.
REQ-012 Port: halted  output  1  high while in HALT.
REQ-013 Port: retired  output  CNT_W  count of executed instructions.

Function
REQ-014 FSM states: BOOT, RUN, HALT; the FSM SHALL go BOOT->RUN after one cycle, RUN->HALT on illegal instruction or self-loop, and leave HALT only via rst.
REQ-015 AD1=instr[19:15], AD2=instr[24:20], AD3=instr[11:7] SHALL be driven combinationally in all states.
REQ-016 addi (opcode 0010011, funct3 000): WE3=1, ALUSrc=1, ALUCtrl=0, ImmOp=sext(instr[31:20]).
REQ-017 add/sub (opcode 0110011, funct3 000, funct7 0000000/0100000): WE3=1, ALUSrc=0, ALUCtrl=0/1, ImmOp=0.
REQ-018 bne (opcode 1100011, funct3 001): WE3=0, ALUSrc=0, ALUCtrl=1, ImmOp=sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
REQ-019 Any other encoding SHALL be illegal: WE3=0, ALUSrc=0, ALUCtrl=0, ImmOp=0.
REQ-020 In RUN with stall=0 and legal instr: next PC = PC+ImmOp if bne and EQ=0, else PC+4; addition modulo 2^32 (wrap from 32'hFFFF_FFFC to 0 permitted).
REQ-021 bne taken with ImmOp[1]=1 (misaligned target) SHALL be treated as illegal.
REQ-022 bne taken with ImmOp=0 (branch to self) SHALL enter HALT; PC holds.
REQ-023 On illegal instr in RUN (stall=0): enter HALT next cycle, PC holds, no write.
REQ-024 In BOOT, HALT, or when stall=1: WE3 forced 0, PC holds, FSM does not transition (stall dominates illegal/self-loop detection).
REQ-025 retired SHALL increment by 1 for each RUN cycle with stall=0 and a legal, non-halting instruction; it SHALL saturate at all-ones.
REQ-026 halted SHALL be a registered decode of state==HALT.

Reset
REQ-027 While rst=1 at a clock edge: PC<=PC_RESET, state<=BOOT, retired<=0; halted=0 the following cycle.
REQ-028 rst SHALL take priority over stall and any instruction; reset mid-branch discards the branch.
REQ-029 During and for the first cycle after reset, WE3=0.

Verification
REQ-030 rst 1 cycle, instr=addi x10,x0,5 (32'h0050_0513) -> BOOT cycle WE3=0, PC=0; next cycle WE3=1, ALUSrc=1, ImmOp=5, AD3=10; PC=4 after edge; retired=1.
REQ-031 instr=bne x10,x0,-4 (32'hFE05_1EE3) at PC=8, EQ=0 -> PC=4; same with EQ=1 -> PC=12; ALUCtrl=1, WE3=0 in both.
REQ-032 instr=sub x3,x1,x2 (32'h4020_81B3) -> ALUCtrl=1, ALUSrc=0, WE3=1; stall=1 same cycle -> WE3=0, PC and retired unchanged.
REQ-033 instr=32'h0000_0000 in RUN -> next cycle halted=1, PC frozen, WE3=0 for 10 further cycles regardless of instr; rst -> PC=0, halted=0.
REQ-034 bne x1,x0,0 (32'h0000_9063), EQ=0 -> HALT, PC unchanged; retired preset to 16'hFFFF via 65535 addi cycles (or force) stays 16'hFFFF after further addi.

Source files
------------

// File: rtl/pc_decode_unit.sv
// pc_decode_unit: program counter, BOOT/RUN/HALT sequencer and decoder for addi/add/sub/bne.
module pc_decode_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [31:0]      instr,
  input  logic             EQ,
  output logic [31:0]      PC,
  output logic [4:0]       AD1,
  output logic [4:0]       AD2,
  output logic [4:0]       AD3,
  output logic             WE3,
  output logic             ALUSrc,
  output logic             ALUCtrl,
  output logic [31:0]      ImmOp,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
  state_t state, state_n;
  logic is_addi, is_r, is_bne, legal, taken, stop, adv;
  logic [31:0] pc_n;
  assign AD1 = instr[19:15];
  assign AD2 = instr[24:20];
  assign AD3 = instr[11:7];
  assign is_addi = instr[6:0] == 7'b0010011 && instr[14:12] == 3'b000;
  assign is_r    = instr[6:0] == 7'b0110011 && instr[14:12] == 3'b000 &&
                   (instr[31:25] == 7'b0000000 || instr[31:25] == 7'b0100000);
  assign is_bne  = instr[6:0] == 7'b1100011 && instr[14:12] == 3'b001;
  assign legal   = is_addi | is_r | is_bne;
  always_comb begin
    ImmOp   = is_addi ? {{20{instr[31]}}, instr[31:20]}
            : is_bne  ? {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0}
            : 32'd0;
    ALUSrc  = is_addi;
    ALUCtrl = is_bne | (is_r & instr[30]);
    taken   = is_bne & ~EQ;
    // misaligned or self-targeting branches stop the core like an illegal opcode
    stop    = ~legal | (taken & (ImmOp[1] | ImmOp == 32'd0));
    adv     = state == RUN && !stall;
    WE3     = adv & ~rst & (is_addi | is_r);
    pc_n    = PC + (taken ? ImmOp : 32'd4);
    state_n = state == BOOT ? RUN : (adv && stop) ? HALT : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      PC      <= PC_RESET;
      state   <= BOOT;
      halted  <= 1'b0;
      retired <= '0;
    end else begin
      state  <= state_n;
      halted <= state_n == HALT;
      if (adv && !stop) begin
        PC <= pc_n;
        if (~&retired) retired <= retired + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pc_decode_unit.sv
// tb_pc_decode_unit: scoreboard bench with an instruction-level reference model.
module tb_pc_decode_unit;
  logic clk, rst, stall, EQ;
  logic [31:0] instr, PC, ImmOp;
  logic [4:0] AD1, AD2, AD3;
  logic WE3, ALUSrc, ALUCtrl, halted;
  logic [15:0] retired;

  pc_decode_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .instr(instr), .EQ(EQ), .PC(PC),
    .AD1(AD1), .AD2(AD2), .AD3(AD3), .WE3(WE3), .ALUSrc(ALUSrc), .ALUCtrl(ALUCtrl),
    .ImmOp(ImmOp), .halted(halted), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  a1, a2, a3;
    logic        we, src, ctl;
    logic [31:0] imm;
    logic        hl;
    logic [15:0] ret;
  } exp_t;

  exp_t q[$];
  int checks = 0, failures = 0;
  logic [31:0] m_pc;
  int m_mode;  // 0 boot, 1 run, 2 halt
  int m_ret;

  localparam logic [31:0] ADDI5 = 32'h0050_0513;
  localparam logic [31:0] BNEM4 = 32'hFE05_1EE3;
  localparam logic [31:0] SUB3  = 32'h4020_81B3;
  localparam logic [31:0] BNE0  = 32'h0000_9063;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at t=%0t", n, got, exp, $time);
    end
  endtask

  // kind: 0 illegal, 1 addi, 2 add, 3 sub, 4 bne
  function automatic void dec(input logic [31:0] i, output int k, output logic [31:0] imm);
    logic signed [11:0] ia;
    logic signed [12:0] ib;
    ia = i[31:20];
    ib = {i[31], i[7], i[30:25], i[11:8], 1'b0};
    k = 0;
    imm = 32'd0;
    if (i[6:0] == 7'h13 && i[14:12] == 3'd0) begin k = 1; imm = ia; end
    else if (i[6:0] == 7'h33 && i[14:12] == 3'd0 && i[31:25] == 7'h00) k = 2;
    else if (i[6:0] == 7'h33 && i[14:12] == 3'd0 && i[31:25] == 7'h20) k = 3;
    else if (i[6:0] == 7'h63 && i[14:12] == 3'd1) begin k = 4; imm = ib; end
  endfunction

  function automatic logic [31:0] bne_enc(input logic [12:0] o, input logic [4:0] r1, input logic [4:0] r2);
    return {o[12], o[10:5], r2, r1, 3'b001, o[4:1], o[11], 7'b1100011};
  endfunction

  task automatic step(input logic r, input logic s, input logic [31:0] i, input logic e);
    exp_t x;
    int k;
    logic [31:0] imm;
    bit tk;
    rst = r; stall = s; instr = i; EQ = e;
    dec(i, k, imm);
    x.pc = m_pc; x.a1 = i[19:15]; x.a2 = i[24:20]; x.a3 = i[11:7];
    x.we = (k >= 1 && k <= 3) && m_mode == 1 && !s && !r;
    x.src = k == 1; x.ctl = k == 3 || k == 4; x.imm = imm;
    x.hl = m_mode == 2; x.ret = 16'(m_ret);
    q.push_back(x);
    @(posedge clk); #1;
    if (r) begin
      m_pc = 32'd0; m_mode = 0; m_ret = 0;
    end else if (m_mode == 0) m_mode = 1;
    else if (m_mode == 1 && !s) begin
      tk = k == 4 && !e;
      if (k == 0 || (tk && (imm[1] || imm == 32'd0))) m_mode = 2;
      else begin
        m_pc = m_pc + (tk ? imm : 32'd4);
        if (m_ret < 65535) m_ret++;
      end
    end
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [12:0] o;
    int c;
    c = $urandom_range(0, 9);
    o = 13'($urandom) & 13'h1FFE;
    if ($urandom_range(0, 3) != 0) o[1] = 1'b0;
    if (c <= 2) return {12'($urandom), 5'($urandom), 3'b000, 5'($urandom), 7'h13};
    if (c <= 4) return {1'b0, 1'($urandom), 5'd0, 5'($urandom), 5'($urandom), 3'b000, 5'($urandom), 7'h33};
    if (c <= 7) return bne_enc(o, 5'($urandom), 5'($urandom));
    if (c == 8) return $urandom;
    return 32'd0;
  endfunction

  always @(negedge clk) begin
    exp_t x;
    if (q.size() > 0) begin
      x = q.pop_front();
      chk("PC", PC, x.pc);
      chk("AD1", 32'(AD1), 32'(x.a1));
      chk("AD2", 32'(AD2), 32'(x.a2));
      chk("AD3", 32'(AD3), 32'(x.a3));
      chk("WE3", 32'(WE3), 32'(x.we));
      chk("ALUSrc", 32'(ALUSrc), 32'(x.src));
      chk("ALUCtrl", 32'(ALUCtrl), 32'(x.ctl));
      chk("ImmOp", ImmOp, x.imm);
      chk("halted", 32'(halted), 32'(x.hl));
      chk("retired", 32'(retired), 32'(x.ret));
    end
  end

  initial begin
    rst = 1'b1; stall = 1'b0; instr = ADDI5; EQ = 1'b0;
    @(posedge clk); #1;
    m_pc = 32'd0; m_mode = 0; m_ret = 0;
    // reset, boot, first addi, then bne taken/not taken from PC=8
    step(1, 0, ADDI5, 0);
    step(0, 0, ADDI5, 0);
    step(0, 0, ADDI5, 0);
    step(0, 0, ADDI5, 0);
    step(0, 0, BNEM4, 0);
    step(0, 0, ADDI5, 0);
    step(0, 0, BNEM4, 1);
    step(0, 0, SUB3, 0);
    step(0, 1, SUB3, 0);
    step(0, 1, 32'd0, 0);
    step(0, 0, 32'd0, 0);
    repeat (10) step(0, 0, rnd_instr(), 1'($urandom));
    step(1, 1, BNEM4, 0);
    step(0, 0, ADDI5, 0);
    // wrap backwards past zero and forward again
    step(0, 0, ADDI5, 0);
    step(0, 0, bne_enc(13'h1FF8, 5'd1, 5'd0), 0);
    step(0, 0, ADDI5, 0);
    step(0, 0, BNE0, 0);
    step(0, 0, ADDI5, 0);
    step(1, 0, ADDI5, 0);
    step(0, 0, ADDI5, 0);
    step(0, 0, bne_enc(13'h0006, 5'd1, 5'd0), 0);
    step(0, 0, ADDI5, 0);
    // mid-branch reset
    step(1, 0, ADDI5, 0);
    step(0, 0, ADDI5, 0);
    step(1, 0, BNEM4, 0);
    step(0, 0, ADDI5, 0);
    for (int n = 0; n < 3000; n++)
      step(($urandom_range(0, 39) == 0) || (m_mode == 2 && $urandom_range(0, 3) == 0),
           $urandom_range(0, 4) == 0, rnd_instr(), 1'($urandom));
    // retired counter saturation
    step(1, 0, ADDI5, 0);
    step(0, 0, ADDI5, 0);
    for (int n = 0; n < 65540; n++) step(0, 0, ADDI5, 0);
    step(0, 0, BNE0, 0);
    step(0, 0, ADDI5, 0);
    step(0, 0, ADDI5, 0);
    @(negedge clk);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
